uart_rx_loader: RTL and testbench

Downstream consumer of the UART receiver (`async_receiver`) in the processor FPGA. Takes received bytes, recognises a framed program/data load, packs bytes into memory words and issues write strobes to the processor memory port. Holds the processor via `busy` while a load is in progress and reports success or failure per frame.

---
 rtl/uart_loader_pkg.sv | 21 ++
 rtl/uart_rx_loader_if.sv | 28 ++
 rtl/uart_rx_loader_byte_packer.sv | 44 ++++
 rtl/uart_rx_loader.sv | 139 +++++++++++++
 tb/tb_uart_rx_loader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types for the UART program/data loader.
// CSUM state exists only when UART_LOADER_CSUM_EN is defined.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
`ifdef UART_LOADER_CSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic int WORD_W(input int wordBytes);
    return 8 * wordBytes;
  endfunction

endpackage

// File: rtl/uart_rx_loader_if.sv
// Receiver-side byte stream and memory write port of the loader.
// Signal set is the same with or without UART_LOADER_CSUM_EN.
interface uart_rx_loader_if #(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 2
);
  logic                    rx_data_ready;
  logic [7:0]              rx_data;
  logic                    rx_endofpacket;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [8*WORD_BYTES-1:0] mem_wdata;
  logic                    busy;
  logic                    load_done;
  logic                    load_error;

  modport master (
    output rx_data_ready, rx_data, rx_endofpacket,
    input  mem_we, mem_addr, mem_wdata,
    input  busy, load_done, load_error
  );

  modport slave (
    input  rx_data_ready, rx_data, rx_endofpacket,
    output mem_we, mem_addr, mem_wdata,
    output busy, load_done, load_error
  );
endinterface

// File: rtl/uart_rx_loader_byte_packer.sv
// MSB-first byte-to-word packer with registered word strobe.
// Independent of UART_LOADER_CSUM_EN.
module byte_packer
  import uart_loader_pkg::*;
#(
  parameter  int WORD_BYTES = 2,
  localparam int W = WORD_W(WORD_BYTES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         byteValid,
  input  logic [7:0]   byteIn,
  output logic         wordEnd,
  output logic         wordValid,
  output logic [W-1:0] word
);
  logic [7:0]   cnt;
  logic [W-1:0] sh;
  logic [W-1:0] shNext;

  assign wordEnd = byteValid && cnt == 8'(WORD_BYTES - 1);
  assign shNext  = (sh << 8) | W'(byteIn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 8'd0;
      sh        <= '0;
      wordValid <= 1'b0;
      word      <= '0;
    end else begin
      wordValid <= wordEnd;
      if (clear) begin
        cnt <= 8'd0;
        sh  <= '0;
      end else if (byteValid) begin
        sh  <= shNext;
        cnt <= wordEnd ? 8'd0 : cnt + 8'd1;
      end
      // word holds steady between strobes
      if (wordEnd) word <= shNext;
    end
  end
endmodule

// File: rtl/uart_rx_loader.sv
// Framed UART loader: SYNC, N, N words, optional XOR checksum.
// Checksum stage is built only when UART_LOADER_CSUM_EN is defined.
module uart_rx_loader
  import uart_loader_pkg::*;
#(
  parameter int         ADDR_W     = 8,
  parameter int         WORD_BYTES = 2,
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  uart_rx_loader_if.slave bus
);
  localparam int W = WORD_W(WORD_BYTES);

  state_t            state;
  state_t            stateNext;
  logic [7:0]        len;
  logic [7:0]        wordCnt;
  logic [ADDR_W-1:0] addr;
  logic              errReg;
  logic              accept;
  logic              isSync;
  logic              syncGo;
  logic              inFrame;
  logic              abortGo;
  logic              byteValid;
  logic              lastWord;
  logic              wordEnd;
  logic              wordValid;
  logic [W-1:0]      word;
  logic              inCsum;
  logic              csumBad;

  // abort beats a coincident byte
  assign accept    = bus.rx_data_ready && !bus.rx_endofpacket;
  assign isSync    = accept && bus.rx_data == SYNC_BYTE;
  assign syncGo    = isSync && (state == IDLE || state == DONE);
  assign inFrame   = state == LEN || state == DATA || inCsum;
  assign abortGo   = inFrame && bus.rx_endofpacket;
  assign byteValid = state == DATA && accept;
  assign lastWord  = wordEnd && wordCnt == len - 8'd1;

`ifdef UART_LOADER_CSUM_EN
  localparam state_t AFTER_DATA = CSUM;
  logic [7:0] csum;
  assign inCsum  = state == CSUM;
  assign csumBad = inCsum && accept && bus.rx_data != csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            csum <= 8'd0;
    else if (syncGo)    csum <= 8'd0;
    else if (byteValid) csum <= csum ^ bus.rx_data;
  end
`else
  localparam state_t AFTER_DATA = DONE;
  assign inCsum  = 1'b0;
  assign csumBad = 1'b0;
`endif

  byte_packer #(.WORD_BYTES(WORD_BYTES)) packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state != DATA),
    .byteValid (byteValid),
    .byteIn    (bus.rx_data),
    .wordEnd   (wordEnd),
    .wordValid (wordValid),
    .word      (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // DONE also listens for SYNC so a following frame is not lost
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (isSync) stateNext = LEN;
      LEN: begin
        if (bus.rx_endofpacket) stateNext = IDLE;
        else if (accept)
          stateNext = (bus.rx_data == 8'd0) ? AFTER_DATA : DATA;
      end
      DATA: begin
        if (bus.rx_endofpacket) stateNext = IDLE;
        else if (lastWord)      stateNext = AFTER_DATA;
      end
`ifdef UART_LOADER_CSUM_EN
      CSUM: begin
        if (bus.rx_endofpacket) stateNext = IDLE;
        else if (accept)        stateNext = csumBad ? IDLE : DONE;
      end
`endif
      DONE:    stateNext = isSync ? LEN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.load_done = 1'b0;
    unique case (state)
      LEN, DATA: bus.busy = 1'b1;
`ifdef UART_LOADER_CSUM_EN
      CSUM: bus.busy = 1'b1;
`endif
      DONE:    bus.load_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len     <= 8'd0;
      wordCnt <= 8'd0;
      addr    <= '0;
      errReg  <= 1'b0;
    end else begin
      if (state == LEN && accept) len <= bus.rx_data;
      if (syncGo) begin
        wordCnt <= 8'd0;
        addr    <= '0;
      end else begin
        if (wordEnd)   wordCnt <= wordCnt + 8'd1;
        if (wordValid) addr    <= addr + 1'b1;
      end
      if (syncGo)                  errReg <= 1'b0;
      else if (abortGo || csumBad) errReg <= 1'b1;
    end
  end

  assign bus.mem_we     = wordValid;
  assign bus.mem_addr   = addr;
  assign bus.mem_wdata  = word;
  assign bus.load_error = errReg;
endmodule

// File: tb/tb_uart_rx_loader.sv
// Scoreboard bench for uart_rx_loader; follows UART_LOADER_CSUM_EN
// to append checksum bytes and run the bad-checksum case.
module tb_uart_rx_loader;
  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  wr_t  wrQ[$];
  int   doneQ[$];
  wr_t  w;
  int   dc;

  uart_rx_loader_if #(.ADDR_W(8), .WORD_BYTES(2)) bus();

  uart_rx_loader #(
    .ADDR_W(8), .WORD_BYTES(2), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.rx_data_ready = 1'b1;
    bus.rx_data       = b;
    @(posedge clk); #1;
    bus.rx_data_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expW(input logic [7:0] a, input logic [15:0] d);
    wrQ.push_back('{a, d, cyc});
  endtask

  task automatic expD();
    doneQ.push_back(cyc);
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_we"},    32'(bus.mem_we),     0);
    chk({tag, "_addr"},  32'(bus.mem_addr),   0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata),  0);
    chk({tag, "_busy"},  32'(bus.busy),       0);
    chk({tag, "_done"},  32'(bus.load_done),  0);
    chk({tag, "_err"},   32'(bus.load_error), 0);
  endtask

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      checks++;
      if (wrQ.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected addr=%0h data=%0h cyc=%0d",
                 bus.mem_addr, bus.mem_wdata, cyc);
      end else begin
        w = wrQ.pop_front();
        if (bus.mem_addr !== w.addr || bus.mem_wdata !== w.data ||
            cyc != w.cyc) begin
          errors++;
          $display("FAIL write got a=%0h d=%0h c=%0d exp a=%0h d=%0h c=%0d",
                   bus.mem_addr, bus.mem_wdata, cyc,
                   w.addr, w.data, w.cyc);
        end
      end
    end
    if (bus.load_done === 1'b1) begin
      checks++;
      if (doneQ.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d", cyc);
      end else begin
        dc = doneQ.pop_front();
        if (cyc != dc) begin
          errors++;
          $display("FAIL done_cycle got=%0d exp=%0d", cyc, dc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    bus.rx_data_ready  = 1'b0;
    bus.rx_data        = 8'h00;
    bus.rx_endofpacket = 1'b0;
    #2;
    chkReset("rst0");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // two-word frame, back-to-back bytes
    sendByte(8'hA5);
    chk("busy_rise", 32'(bus.busy), 1);
    sendByte(8'h02);
    sendByte(8'h12);
    sendByte(8'h34); expW(8'd0, 16'h1234);
    sendByte(8'h56);
    sendByte(8'h78); expW(8'd1, 16'h5678);
`ifdef UART_LOADER_CSUM_EN
    chk("busy_csum", 32'(bus.busy), 1);
    sendByte(8'h08);
`endif
    expD();
    chk("t1_busy", 32'(bus.busy), 0);
    chk("t1_err",  32'(bus.load_error), 0);
    idle(2);

`ifdef UART_LOADER_CSUM_EN
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'hAB);
    sendByte(8'hCD); expW(8'd0, 16'hABCD);
    sendByte(8'h00);
    chk("bad_err",  32'(bus.load_error), 1);
    chk("bad_busy", 32'(bus.busy), 0);
    idle(2);
`endif

    // junk before sync, zero-length frame
    sendByte(8'h00);
    sendByte(8'hFF);
    sendByte(8'hA5);
    sendByte(8'h00);
`ifdef UART_LOADER_CSUM_EN
    sendByte(8'h00);
`endif
    expD();
    idle(2);

    // abort mid-frame, then sync clears the error
    sendByte(8'hA5);
    sendByte(8'h03);
    sendByte(8'h11);
    sendByte(8'h22); expW(8'd0, 16'h1122);
    sendByte(8'h33);
    bus.rx_endofpacket = 1'b1;
    @(posedge clk); #1;
    bus.rx_endofpacket = 1'b0;
    chk("abort_err",  32'(bus.load_error), 1);
    chk("abort_busy", 32'(bus.busy), 0);
    sendByte(8'hA5);
    chk("sync_clr_err", 32'(bus.load_error), 0);
    chk("sync_busy",    32'(bus.busy), 1);
    sendByte(8'h00);
`ifdef UART_LOADER_CSUM_EN
    sendByte(8'h00);
`endif
    expD();
    idle(2);

    // abort coincident with the word's final byte
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'hAB);
    bus.rx_data_ready  = 1'b1;
    bus.rx_data        = 8'hCD;
    bus.rx_endofpacket = 1'b1;
    @(posedge clk); #1;
    bus.rx_data_ready  = 1'b0;
    bus.rx_endofpacket = 1'b0;
    chk("coinc_err",  32'(bus.load_error), 1);
    chk("coinc_busy", 32'(bus.busy), 0);
    idle(3);

    // asynchronous reset mid-frame
    sendByte(8'hA5);
    sendByte(8'h02);
    sendByte(8'h12);
    #2 rst = 1'b1;
    #1 chkReset("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // fresh frame after reset starts at address 0
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'hDE);
    sendByte(8'hAD); expW(8'd0, 16'hDEAD);
`ifdef UART_LOADER_CSUM_EN
    sendByte(8'h73);
`endif
    expD();
    chk("last_busy", 32'(bus.busy), 0);
    idle(3);

    chk("wrQ_empty",   32'(wrQ.size()),   0);
    chk("doneQ_empty", 32'(doneQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
